// File: rtl/alu_word_seq_pkg.sv
// Shared definitions for the byte-serial word sequencer: ALU op codes,
// carry-variant op mapping and the sequencer FSM state encoding.
package alu_word_seq_pkg;

    // ALU op codes, identical to the encoding the 8-bit ALU decodes
    localparam logic [3:0] OP_PASS = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADC  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SBC  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_RCL  = 4'h9;
    localparam logic [3:0] OP_SLO  = 4'ha;
    localparam logic [3:0] OP_ROL  = 4'hb;
    localparam logic [3:0] OP_SHR  = 4'hc;
    localparam logic [3:0] OP_RCR  = 4'hd;
    localparam logic [3:0] OP_ROR  = 4'he;
    localparam logic [3:0] OP_SRA  = 4'hf;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Logic ops have no inter-byte carry, every byte sees the word op unchanged
    function automatic logic is_logic_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_PASS, OP_OR, OP_AND, OP_XOR: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

    // Right shifts must start at the top byte so the carry moves downwards
    function automatic logic is_msb_first(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

    // Op sent for the first byte; rotates become rotate-through-carry with a seeded cin
    function automatic logic [3:0] first_op(input logic [3:0] op);
        logic [3:0] res;
        case (op)
            OP_SLO, OP_ROL: res = OP_RCL;
            OP_ROR, OP_SRA: res = OP_RCR;
            default:        res = op;
        endcase
        return res;
    endfunction

    // Op sent for every byte after the first: the carry-consuming variant
    function automatic logic [3:0] carry_op(input logic [3:0] op);
        logic [3:0] res;
        case (op)
            OP_ADD, OP_ADC:                 res = OP_ADC;
            OP_SUB, OP_SBC:                 res = OP_SBC;
            OP_SHL, OP_RCL, OP_SLO, OP_ROL: res = OP_RCL;
            OP_SHR, OP_RCR, OP_ROR, OP_SRA: res = OP_RCR;
            default:                        res = op;
        endcase
        return res;
    endfunction

    // Carry seed for the first byte: the word cin, or the bit that wraps/extends
    function automatic logic first_cin(input logic [3:0] op, input logic cin,
                                       input logic lsb, input logic msb);
        logic res;
        case (op)
            OP_ADC, OP_SBC, OP_RCL, OP_RCR: res = cin;
            OP_SLO, OP_ROR:                 res = lsb;
            OP_ROL, OP_SRA:                 res = msb;
            OP_ADD, OP_SUB, OP_SHL, OP_SHR: res = 1'b0;
            default:                        res = cin;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_word_seq.sv
// Byte-serial word sequencer: runs one ALU op over a BYTES-wide word by
// feeding the external 8-bit ALU one byte per cycle and chaining the carry.
// Optional macro ALU_WORD_SEQ_ZFLAG_EN adds a resp_zero output flag.
module alu_word_seq
    import alu_word_seq_pkg::*;
#(
    parameter int BYTES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [8*BYTES-1:0] req_a,
    input  logic [8*BYTES-1:0] req_b,
    input  logic               req_cin,
    input  logic               req_xy,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [3:0]         alu_op,
    output logic               alu_cin,
    output logic               alu_xy,
    input  logic [7:0]         alu_q,
    input  logic               alu_cout,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [8*BYTES-1:0] resp_q,
`ifdef ALU_WORD_SEQ_ZFLAG_EN
    output logic               resp_zero,
`endif
    output logic               resp_cout
);

    localparam int W  = 8 * BYTES;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

    seq_state_e     state_q, state_d;
    logic [W-1:0]   a_q, b_q;
    logic [3:0]     op_q;
    logic           cin_q, xy_q;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic [W-1:0]   result_q;
    logic           cout_q;

    logic           accept;
    logic           last_byte;
    logic [CW-1:0]  lane;
    logic [7:0]     byte_a, byte_b;

    assign accept     = req_valid && (state_q == ST_IDLE);
    assign last_byte  = (cnt_q == CW'(BYTES - 1));
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_q     = result_q;
    assign resp_cout  = cout_q;

`ifdef ALU_WORD_SEQ_ZFLAG_EN
    assign resp_zero  = (state_q == ST_DONE) && (result_q == '0);
`endif

    // FSM next state: accept in IDLE, one RUN cycle per byte, hold result until consumed
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_byte)  state_d = ST_DONE;
            ST_DONE: if (resp_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Byte-lane select and per-byte ALU drive; all ALU inputs are quiet outside RUN
    always_comb begin
        lane   = is_msb_first(op_q) ? (CW'(BYTES - 1) - cnt_q) : cnt_q;
        byte_a = '0;
        byte_b = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (lane == CW'(i)) begin
                byte_a = a_q[i*8 +: 8];
                byte_b = b_q[i*8 +: 8];
            end
        end
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = '0;
        alu_cin = 1'b0;
        alu_xy  = 1'b0;
        if (state_q == ST_RUN) begin
            alu_a  = byte_a;
            alu_b  = byte_b;
            alu_xy = xy_q;
            if (is_logic_op(op_q)) begin
                alu_op  = op_q;
                alu_cin = cin_q;
            end else if (cnt_q == '0) begin
                alu_op  = first_op(op_q);
                alu_cin = first_cin(op_q, cin_q, a_q[0], a_q[W-1]);
            end else begin
                alu_op  = carry_op(op_q);
                alu_cin = carry_q;
            end
        end
    end

    // State register, request latch and per-byte capture of the ALU result and carry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            xy_q     <= 1'b0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= req_a;
                b_q   <= req_b;
                op_q  <= req_op;
                cin_q <= req_cin;
                xy_q  <= req_xy;
                cnt_q <= '0;
            end
            if (state_q == ST_RUN) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (lane == CW'(i)) begin
                        result_q[i*8 +: 8] <= alu_q;
                    end
                end
                carry_q <= alu_cout;
                cout_q  <= alu_cout;
                cnt_q   <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_word_seq.sv
// Directed self-checking bench for alu_word_seq with BYTES=2. The bench owns a
// behavioural 8-bit ALU that answers the sequencer's byte requests.
module tb_alu_word_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_cin;
    logic        req_xy;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic        alu_xy;
    logic [7:0]  alu_q;
    logic        alu_cout;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_q;
    logic        resp_cout;
`ifdef ALU_WORD_SEQ_ZFLAG_EN
    logic        resp_zero;
`endif

    int checks;
    int errors;

    alu_word_seq #(.BYTES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .req_xy     (req_xy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_cin    (alu_cin),
        .alu_xy     (alu_xy),
        .alu_q      (alu_q),
        .alu_cout   (alu_cout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_q     (resp_q),
`ifdef ALU_WORD_SEQ_ZFLAG_EN
        .resp_zero  (resp_zero),
`endif
        .resp_cout  (resp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU: logic ops, add/sub with optional carry, shifts through carry
    logic [8:0] sum;
    logic [7:0] beff;
    always_comb begin
        sum      = '0;
        beff     = alu_xy ? ~alu_b : alu_b;
        alu_q    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            4'h0: alu_q = alu_a;
            4'h1: alu_q = alu_a | beff;
            4'h2: alu_q = alu_a & beff;
            4'h3: alu_q = alu_a ^ beff;
            4'h4, 4'h5, 4'h6, 4'h7: begin
                if (alu_op[1]) sum = {1'b0, alu_a} + {1'b0, ~alu_b} + (alu_op[0] ? {8'd0, alu_cin} : 9'd1);
                else           sum = {1'b0, alu_a} + {1'b0,  alu_b} + (alu_op[0] ? {8'd0, alu_cin} : 9'd0);
                alu_q    = sum[7:0];
                alu_cout = sum[8];
            end
            4'h8: begin alu_q = {alu_a[6:0], 1'b0};    alu_cout = alu_a[7]; end
            4'h9, 4'ha, 4'hb: begin alu_q = {alu_a[6:0], alu_cin}; alu_cout = alu_a[7]; end
            4'hc: begin alu_q = {1'b0, alu_a[7:1]};    alu_cout = alu_a[0]; end
            default: begin alu_q = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0]; end
        endcase
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Offer one request, record first two RUN-cycle ALU drives, wait for the response
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic xy,
                          output logic [15:0] q, output logic cout, output int lat,
                          output logic [7:0] a0, output logic [3:0] op0, output logic cin0,
                          output logic [7:0] a1, output logic [3:0] op1, output logic cin1);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_xy    = xy;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        a0  = alu_a;
        op0 = alu_op;
        cin0 = alu_cin;
        a1  = '0;
        op1 = '0;
        cin1 = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                a1   = alu_a;
                op1  = alu_op;
                cin1 = alu_cin;
            end
        end
        q    = resp_q;
        cout = resp_cout;
    endtask

    // Consume the pending response with a single resp_ready pulse
    task automatic release_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_q !== 16'h0)    begin errors++; $display("[TB] FAIL reset_resp_q: got %h expected 0000", resp_q); end
        checks++; if (resp_cout !== 1'b0)  begin errors++; $display("[TB] FAIL reset_resp_cout: got %b expected 0", resp_cout); end
        checks++; if ({alu_a, alu_b, alu_op, alu_cin, alu_xy} !== 22'h0)
            begin errors++; $display("[TB] FAIL reset_alu: got a=%h b=%h op=%h cin=%b xy=%b expected all 0", alu_a, alu_b, alu_op, alu_cin, alu_xy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [15:0] q; logic c; int lat;
        logic [7:0] a0, a1; logic [3:0] op0, op1; logic c0, c1;
        run_op(4'h4, 16'h00FF, 16'h0001, 1'b0, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if (lat !== 2)       begin errors++; $display("[TB] FAIL add_latency: got %0d expected 2", lat); end
        checks++; if (q !== 16'h0100)  begin errors++; $display("[TB] FAIL add_q: got %h expected 0100", q); end
        checks++; if (c !== 1'b0)      begin errors++; $display("[TB] FAIL add_cout: got %b expected 0", c); end
        checks++; if ({a0, op0} !== {8'hFF, 4'h4}) begin errors++; $display("[TB] FAIL add_byte0: got a=%h op=%h expected a=ff op=4", a0, op0); end
        checks++; if ({op1, c1} !== {4'h5, 1'b1})  begin errors++; $display("[TB] FAIL add_byte1: got op=%h cin=%b expected op=5 cin=1", op1, c1); end
        release_resp();
    endtask

    task automatic test_sub();
        logic [15:0] q; logic c; int lat;
        logic [7:0] a0, a1; logic [3:0] op0, op1; logic c0, c1;
        run_op(4'h6, 16'h1000, 16'h0001, 1'b0, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if ({q, c} !== {16'h0FFF, 1'b1}) begin errors++; $display("[TB] FAIL sub_nb: got q=%h cout=%b expected q=0fff cout=1", q, c); end
        checks++; if ({op1, c1} !== {4'h7, 1'b0})  begin errors++; $display("[TB] FAIL sub_byte1: got op=%h cin=%b expected op=7 cin=0", op1, c1); end
        release_resp();
        run_op(4'h6, 16'h0000, 16'h0001, 1'b0, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if ({q, c} !== {16'hFFFF, 1'b0}) begin errors++; $display("[TB] FAIL sub_borrow: got q=%h cout=%b expected q=ffff cout=0", q, c); end
        release_resp();
    endtask

    task automatic test_rotate_left();
        logic [15:0] q; logic c; int lat;
        logic [7:0] a0, a1; logic [3:0] op0, op1; logic c0, c1;
        run_op(4'hB, 16'h8001, 16'h0000, 1'b0, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if ({q, c} !== {16'h0003, 1'b1}) begin errors++; $display("[TB] FAIL rol_result: got q=%h cout=%b expected q=0003 cout=1", q, c); end
        checks++; if ({a0, op0, c0} !== {8'h01, 4'h9, 1'b1}) begin errors++; $display("[TB] FAIL rol_byte0: got a=%h op=%h cin=%b expected a=01 op=9 cin=1", a0, op0, c0); end
        checks++; if ({a1, op1, c1} !== {8'h80, 4'h9, 1'b0}) begin errors++; $display("[TB] FAIL rol_byte1: got a=%h op=%h cin=%b expected a=80 op=9 cin=0", a1, op1, c1); end
        release_resp();
    endtask

    task automatic test_shift_right();
        logic [15:0] q; logic c; int lat;
        logic [7:0] a0, a1; logic [3:0] op0, op1; logic c0, c1;
        run_op(4'hC, 16'h0101, 16'h0000, 1'b0, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if ({q, c} !== {16'h0080, 1'b1}) begin errors++; $display("[TB] FAIL shr_result: got q=%h cout=%b expected q=0080 cout=1", q, c); end
        release_resp();
        run_op(4'hD, 16'h1234, 16'h0000, 1'b1, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if ({q, c} !== {16'h891A, 1'b0}) begin errors++; $display("[TB] FAIL rcr_result: got q=%h cout=%b expected q=891a cout=0", q, c); end
        checks++; if ({a0, op0, c0} !== {8'h12, 4'hD, 1'b1}) begin errors++; $display("[TB] FAIL rcr_byte0: got a=%h op=%h cin=%b expected a=12 op=d cin=1", a0, op0, c0); end
        checks++; if ({a1, op1, c1} !== {8'h34, 4'hD, 1'b0}) begin errors++; $display("[TB] FAIL rcr_byte1: got a=%h op=%h cin=%b expected a=34 op=d cin=0", a1, op1, c1); end
        release_resp();
    endtask

    task automatic test_logic_hold();
        logic [15:0] q; logic c; int lat;
        logic [7:0] a0, a1; logic [3:0] op0, op1; logic c0, c1;
        int bad;
        run_op(4'h1, 16'h1200, 16'hFF0F, 1'b1, 1'b1, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if ({q, c} !== {16'h12F0, 1'b0}) begin errors++; $display("[TB] FAIL or_xy_result: got q=%h cout=%b expected q=12f0 cout=0", q, c); end
        checks++; if ({op0, c0, op1, c1} !== {4'h1, 1'b1, 4'h1, 1'b1}) begin errors++; $display("[TB] FAIL or_xy_ops: got %h/%b %h/%b expected 1/1 1/1", op0, c0, op1, c1); end
        release_resp();
        run_op(4'h2, 16'h00F0, 16'h0F0F, 1'b0, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if (q !== 16'h0000) begin errors++; $display("[TB] FAIL and_result: got %h expected 0000", q); end
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'h4;
        req_a     = 16'h1111;
        req_b     = 16'h2222;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_q !== 16'h0000 || alu_op !== 4'h0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL done_hold: got %0d unstable cycles expected 0 (valid=%b ready=%b q=%h)", bad, resp_valid, req_ready, resp_q); end
        @(negedge clk);
        req_valid = 1'b0;
        release_resp();
        checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("[TB] FAIL release_idle: got ready=%b valid=%b expected ready=1 valid=0", req_ready, resp_valid); end
    endtask

    task automatic test_abort();
        int seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'h4;
        req_a     = 16'hA5A5;
        req_b     = 16'h0101;
        req_cin   = 1'b1;
        req_xy    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if ({alu_a, alu_op} !== {8'hA5, 4'h4}) begin errors++; $display("[TB] FAIL abort_running: got a=%h op=%h expected a=a5 op=4", alu_a, alu_op); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("[TB] FAIL abort_ctl: got valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready); end
        checks++; if ({alu_a, alu_b, alu_op, alu_cin, alu_xy} !== 22'h0)
            begin errors++; $display("[TB] FAIL abort_alu: got a=%h b=%h op=%h cin=%b xy=%b expected all 0", alu_a, alu_b, alu_op, alu_cin, alu_xy); end
        checks++; if ({resp_q, resp_cout} !== 17'h0) begin errors++; $display("[TB] FAIL abort_resp: got q=%h cout=%b expected 0", resp_q, resp_cout); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_resp: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q; logic c; int lat;
        logic [7:0] a0, a1; logic [3:0] op0, op1; logic c0, c1;
        run_op(4'h5, 16'hFFFF, 16'h0000, 1'b1, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if ({q, c} !== {16'h0000, 1'b1}) begin errors++; $display("[TB] FAIL adc_wrap: got q=%h cout=%b expected q=0000 cout=1", q, c); end
        release_resp();
        run_op(4'h7, 16'h0005, 16'h0003, 1'b1, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 2", lat); end
        checks++; if ({q, c} !== {16'h0002, 1'b1}) begin errors++; $display("[TB] FAIL sbc_result: got q=%h cout=%b expected q=0002 cout=1", q, c); end
        release_resp();
    endtask

`ifdef ALU_WORD_SEQ_ZFLAG_EN
    task automatic test_zero_flag();
        logic [15:0] q; logic c; int lat;
        logic [7:0] a0, a1; logic [3:0] op0, op1; logic c0, c1;
        run_op(4'h3, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, q, c, lat, a0, op0, c0, a1, op1, c1);
        checks++; if ({q, resp_zero} !== {16'h0000, 1'b1}) begin errors++; $display("[TB] FAIL zero_flag: got q=%h zero=%b expected q=0000 zero=1", q, resp_zero); end
        release_resp();
        checks++; if (resp_zero !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle: got %b expected 0", resp_zero); end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = 1'b0;
        req_xy     = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_rotate_left();
        test_shift_right();
        test_logic_hold();
        test_abort();
        test_back_to_back();
`ifdef ALU_WORD_SEQ_ZFLAG_EN
        test_zero_flag();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
